// File: rtl/mgt_01_ctx_save_restore_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mgt_01_ctx_save_restore_pkg
// Purpose  : Shared types and constants for the context save/restore engine.
//            Provides the data bus type, the frame geometry and the FSM
//            state encoding used by the engine, its address generator and
//            its memory-port interface.
// Revision : 1.0 - initial release
// ============================================================================
package mgt_01_ctx_save_restore_pkg;

    localparam int XLEN            = 32;
    localparam int WORD_BYTES      = 4;
    // x0 is hard-wired to zero and never travels, so the frame holds x1..x31.
    localparam int CTX_FRAME_WORDS = 31;
    localparam int CTX_IDX_W       = 5;

    typedef logic [XLEN-1:0] data_bus_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SNAP   = 3'd1,
        ST_STORE  = 3'd2,
        ST_LOAD   = 3'd3,
        ST_COMMIT = 3'd4,
        ST_DONE   = 3'd5
    } ctx_state_e;

endpackage
`default_nettype wire

// File: rtl/mgt_01_ctx_save_restore_if.sv
`default_nettype none
// ============================================================================
// Module   : mgt_01_ctx_save_restore_if
// Purpose  : Data-memory port between the context engine and memory.
//            Signal names keep the engine-side direction suffix.
// Ports    : mem_req_o   - request (engine -> memory)
//            mem_we_o    - 1 = store, 0 = load
//            mem_addr_o  - byte address
//            mem_wdata_o - store data
//            mem_ack_i   - transfer complete; load data valid this cycle
//            mem_rdata_i - load data
// Modports : master (engine side), slave (memory side)
// Revision : 1.0 - initial release
// ============================================================================
interface mgt_01_ctx_save_restore_if;
    import mgt_01_ctx_save_restore_pkg::*;

    logic      mem_req_o;
    logic      mem_we_o;
    data_bus_t mem_addr_o;
    data_bus_t mem_wdata_o;
    logic      mem_ack_i;
    data_bus_t mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );

endinterface
`default_nettype wire

// File: rtl/mgt_01_ctx_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : mgt_01_ctx_addr_gen
// Purpose  : Frame slot counter and address adder for the context engine.
//            addr_o = base + (idx-1)*WORD_BYTES, modulo 2^XLEN (wrap-around
//            is intentional and not flagged).
// Ports    : clk_i, rst_i - clock, synchronous active-high reset
//            load_i       - latch base_i and set idx to 1
//            base_i       - frame base byte address
//            inc_i        - advance to the next slot
//            idx_o        - current slot index (1..31)
//            addr_o       - byte address of the current slot
//            last_o       - current slot is the final one (idx = 31)
// Revision : 1.0 - initial release
// ============================================================================
module mgt_01_ctx_addr_gen #(
    parameter int XLEN       = 32,
    parameter int WORD_BYTES = 4
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    input  wire logic            load_i,
    input  wire logic [XLEN-1:0] base_i,
    input  wire logic            inc_i,
    output      logic [4:0]      idx_o,
    output      logic [XLEN-1:0] addr_o,
    output      logic            last_o
);
    import mgt_01_ctx_save_restore_pkg::CTX_FRAME_WORDS;

    logic [4:0]      idx_q,  idx_d;
    logic [XLEN-1:0] base_q, base_d;
    logic [XLEN-1:0] w_offset;

    always_comb begin
        idx_d  = idx_q;
        base_d = base_q;
        if (load_i) begin
            idx_d  = 5'd1;
            base_d = base_i;
        end else if (inc_i) begin
            idx_d = idx_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q  <= 5'd1;
            base_q <= '0;
        end else begin
            idx_q  <= idx_d;
            base_q <= base_d;
        end
    end

    // Slot 1 sits at the base itself, hence the idx-1.
    assign w_offset = XLEN'(idx_q - 5'd1) * XLEN'(WORD_BYTES);
    assign addr_o   = base_q + w_offset;
    assign idx_o    = idx_q;
    assign last_o   = (idx_q == 5'(CTX_FRAME_WORDS));

endmodule
`default_nettype wire

// File: rtl/mgt_01_ctx_save_restore.sv
`default_nettype none
// ============================================================================
// Module   : mgt_01_ctx_save_restore
// Purpose  : Context save/restore engine. Save snapshots the integer register
//            file in one cycle and stores x1..x31 to a memory frame; restore
//            loads x1..x31 from the frame and bulk-writes the register file
//            in a single COMMIT cycle.
// Ports    : clk_i, rst_i        - clock, synchronous active-high reset
//            save_req_i          - start save (IDLE only, wins over restore)
//            restore_req_i       - start restore (IDLE only)
//            frame_base_i        - frame base byte address, latched at start
//            busy_o              - high in every state except IDLE
//            done_o              - one-cycle completion pulse
//            rf_snap_i           - full register-file contents (x0 ignored)
//            rf_load_o           - bulk-load data (x0 driven 0)
//            rf_sel_all_o, rf_we_o, rf_clk_en_o - bulk-load strobes (COMMIT)
//            mem                 - data-memory port (master modport)
// Revision : 1.0 - initial release
// ============================================================================
module mgt_01_ctx_save_restore #(
    parameter int XLEN       = 32,
    parameter int WORD_BYTES = 4
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    input  wire logic            save_req_i,
    input  wire logic            restore_req_i,
    input  wire logic [XLEN-1:0] frame_base_i,
    output      logic            busy_o,
    output      logic            done_o,
    input  wire logic [XLEN-1:0] rf_snap_i [XLEN],
    output      logic [XLEN-1:0] rf_load_o [XLEN],
    output      logic            rf_sel_all_o,
    output      logic            rf_we_o,
    output      logic            rf_clk_en_o,
    mgt_01_ctx_save_restore_if.master mem
);
    import mgt_01_ctx_save_restore_pkg::*;

    ctx_state_e      state_q;
    logic            busy_q;
    logic            done_q;
    logic            commit_q;
    logic            req_q;
    logic            we_q;
    logic [XLEN-1:0] ctx_buf_q [1:CTX_FRAME_WORDS];

    logic            w_start;
    logic            w_inc;
    logic            w_last;
    logic [4:0]      w_idx;
    logic [XLEN-1:0] w_addr;
    logic            w_xfer_state;
    logic            w_unused_snap0;

    // x0 is architecturally zero; its snapshot entry is deliberately dropped.
    assign w_unused_snap0 = ^rf_snap_i[0];

    assign w_start      = (state_q == ST_IDLE) && (save_req_i || restore_req_i);
    assign w_xfer_state = (state_q == ST_STORE) || (state_q == ST_LOAD);
    assign w_inc        = w_xfer_state && mem.mem_ack_i && !w_last;

    mgt_01_ctx_addr_gen #(
        .XLEN       (XLEN),
        .WORD_BYTES (WORD_BYTES)
    ) u_addr_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (w_start),
        .base_i (frame_base_i),
        .inc_i  (w_inc),
        .idx_o  (w_idx),
        .addr_o (w_addr),
        .last_o (w_last)
    );

    // Control outputs are registered: each one is set on the edge that
    // enters the state it belongs to.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            commit_q <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            for (int i = 1; i <= CTX_FRAME_WORDS; i++) begin
                ctx_buf_q[i] <= '0;
            end
        end else begin
            done_q   <= 1'b0;
            commit_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    // Save has priority; a simultaneous restore is dropped.
                    if (save_req_i) begin
                        state_q <= ST_SNAP;
                        busy_q  <= 1'b1;
                    end else if (restore_req_i) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                    end
                end
                ST_SNAP: begin
                    for (int i = 1; i <= CTX_FRAME_WORDS; i++) begin
                        ctx_buf_q[i] <= rf_snap_i[i];
                    end
                    state_q <= ST_STORE;
                    req_q   <= 1'b1;
                    we_q    <= 1'b1;
                end
                ST_STORE: begin
                    // req stays high between slots: one transfer per ack.
                    if (mem.mem_ack_i && w_last) begin
                        state_q <= ST_DONE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (mem.mem_ack_i) begin
                        ctx_buf_q[w_idx] <= mem.mem_rdata_i;
                        if (w_last) begin
                            state_q  <= ST_COMMIT;
                            req_q    <= 1'b0;
                            commit_q <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign rf_sel_all_o = commit_q;
    assign rf_we_o      = commit_q;
    assign rf_clk_en_o  = commit_q;

    // Address and data are gated so the bus reads zero outside a transfer.
    assign mem.mem_req_o   = req_q;
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = req_q ? w_addr : '0;
    assign mem.mem_wdata_o = (req_q && we_q) ? ctx_buf_q[w_idx] : '0;

    // Bulk-load data follows the buffer at all times; only COMMIT strobes it.
    always_comb begin
        rf_load_o[0] = '0;
        for (int i = 1; i < XLEN; i++) begin
            rf_load_o[i] = ctx_buf_q[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mgt_01_ctx_save_restore.sv
`default_nettype none
// ============================================================================
// Module   : tb_mgt_01_ctx_save_restore
// Purpose  : Scoreboard bench for the context save/restore engine with a
//            small memory model supporting a configurable ack delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mgt_01_ctx_save_restore;
    import mgt_01_ctx_save_restore_pkg::*;

    localparam int K_ST = 0;
    localparam int K_LD = 1;
    localparam int K_CM = 2;
    localparam int K_DN = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        save_req;
    logic        restore_req;
    logic [31:0] frame_base;
    logic        busy;
    logic        done;
    logic [31:0] snap    [32];
    logic [31:0] rf_load [32];
    logic        sel_all;
    logic        rf_we;
    logic        rf_clk_en;

    mgt_01_ctx_save_restore_if mem_if ();

    mgt_01_ctx_save_restore #(
        .XLEN       (32),
        .WORD_BYTES (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .save_req_i    (save_req),
        .restore_req_i (restore_req),
        .frame_base_i  (frame_base),
        .busy_o        (busy),
        .done_o        (done),
        .rf_snap_i     (snap),
        .rf_load_o     (rf_load),
        .rf_sel_all_o  (sel_all),
        .rf_we_o       (rf_we),
        .rf_clk_en_o   (rf_clk_en),
        .mem           (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    logic [31:0] mem [64];
    int          delay    = 0;
    int          wait_cnt = 0;

    assign mem_if.mem_ack_i   = mem_if.mem_req_o && (wait_cnt >= delay);
    assign mem_if.mem_rdata_i = mem[mem_if.mem_addr_o[7:2]];

    always @(posedge clk) begin
        if (mem_if.mem_req_o && !mem_if.mem_ack_i) wait_cnt <= wait_cnt + 1;
        else                                       wait_cnt <= 0;
        if (mem_if.mem_req_o && mem_if.mem_ack_i && mem_if.mem_we_o)
            mem[mem_if.mem_addr_o[7:2]] <= mem_if.mem_wdata_o;
    end

    // ---------------- scoreboard ----------------
    ev_t         sbq [$];
    logic [31:0] exp_load [32];
    int          tests = 0;
    int          fails = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic void unexpected(string nm, logic [31:0] v);
        tests++;
        fails++;
        $display("FAIL %s: got event (0x%08h), expected none", nm, v);
    endfunction

    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        ev_t e;
        int  nbad;
        if (rst) begin
            prev_wait = 1'b0;
        end else begin
            if (mem_if.mem_req_o && mem_if.mem_ack_i) begin
                if (sbq.size() == 0) begin
                    unexpected("unexpected_xfer", mem_if.mem_addr_o);
                end else begin
                    e = sbq.pop_front();
                    chk("xfer_kind", mem_if.mem_we_o ? K_ST : K_LD, e.kind);
                    chk("xfer_addr", mem_if.mem_addr_o, e.addr);
                    if (mem_if.mem_we_o) chk("store_data", mem_if.mem_wdata_o, e.data);
                    else                 chk("load_wdata_zero", mem_if.mem_wdata_o, 32'h0);
                end
            end
            if (mem_if.mem_req_o && !mem_if.mem_ack_i && prev_wait)
                chk("addr_stable", mem_if.mem_addr_o, prev_addr);
            prev_wait = mem_if.mem_req_o && !mem_if.mem_ack_i;
            prev_addr = mem_if.mem_addr_o;

            if (sel_all || rf_we || rf_clk_en) begin
                if (sbq.size() == 0) begin
                    unexpected("unexpected_commit", {29'd0, sel_all, rf_we, rf_clk_en});
                end else begin
                    e = sbq.pop_front();
                    chk("commit_kind", K_CM, e.kind);
                    chk("commit_strobes", {29'd0, sel_all, rf_we, rf_clk_en}, 32'h7);
                    chk("commit_x0_zero", rf_load[0], 32'h0);
                    nbad = 0;
                    for (int i = 1; i < 32; i++) if (rf_load[i] !== exp_load[i]) nbad++;
                    chk("commit_load_mismatches", nbad, 0);
                    chk("commit_x31", rf_load[31], exp_load[31]);
                end
            end

            if (done) begin
                if (sbq.size() == 0) begin
                    unexpected("unexpected_done", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("done_kind", K_DN, e.kind);
                    chk("done_busy", busy, 1'b1);
                    if (e.data != 0) chk("done_cycle", cyc, e.data);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk_outputs_zero(string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < 32; i++) if (rf_load[i] !== 32'h0) nz++;
        chk({tag, "_busy"},    busy, 0);
        chk({tag, "_done"},    done, 0);
        chk({tag, "_strobes"}, {29'd0, sel_all, rf_we, rf_clk_en}, 0);
        chk({tag, "_req_we"},  {30'd0, mem_if.mem_req_o, mem_if.mem_we_o}, 0);
        chk({tag, "_addr"},    mem_if.mem_addr_o, 0);
        chk({tag, "_wdata"},   mem_if.mem_wdata_o, 0);
        chk({tag, "_rf_load_nonzero"}, nz, 0);
    endtask

    task automatic wait_idle(string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) break;
        end
        chk({tag, "_sb_drained"}, sbq.size(), 0);
        chk({tag, "_idle"}, busy, 0);
        sbq.delete();
    endtask

    // is_save=1: save (both=1 also raises restore). poke>0: re-request
    // poke cycles after the start. lat=0: no done-cycle check.
    task automatic run_op(bit is_save, bit both, logic [31:0] base, int dly,
                          int lat, int poke, string tag);
        delay = dly;
        @(negedge clk);
        for (int k = 1; k <= 31; k++) begin
            ev_t e;
            e.kind = is_save ? K_ST : K_LD;
            e.addr = base + 32'((k - 1) * 4);
            e.data = is_save ? snap[k] : 32'h0;
            sbq.push_back(e);
        end
        if (!is_save) sbq.push_back('{K_CM, 32'h0, 32'h0});
        sbq.push_back('{K_DN, 32'h0, (lat != 0) ? 32'(cyc + lat) : 32'h0});
        save_req    = is_save;
        restore_req = !is_save || both;
        frame_base  = base;
        @(negedge clk);
        save_req    = 1'b0;
        restore_req = 1'b0;
        if (poke > 0) begin
            repeat (poke) @(negedge clk);
            save_req    = 1'b1;
            restore_req = 1'b1;
            @(negedge clk);
            save_req    = 1'b0;
            restore_req = 1'b0;
        end
        wait_idle(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 1'b1;
        save_req = 1'b0;
        restore_req = 1'b0;
        frame_base = '0;
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        for (int i = 0; i < 32; i++) begin
            snap[i]     = 32'h1000 + i;
            exp_load[i] = 32'h0;
        end
        snap[0] = 32'hBAD0_0000;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;

        // 1: save, zero-wait, base 0x2000
        run_op(1'b1, 1'b0, 32'h0000_2000, 0, 33, 0, "save0");
        chk("save0_word_2078", mem[30], 32'h0000_101F);
        chk("save0_word_2000", mem[0],  32'h0000_1001);

        // 2: restore with 3-cycle ack delay
        for (int k = 1; k <= 31; k++) begin
            mem[k - 1]  <= 32'hA5A5_0000 + k;
            exp_load[k]  = 32'hA5A5_0000 + k;
        end
        run_op(1'b0, 1'b0, 32'h0000_2000, 3, 126, 0, "restore3");
        chk("restore3_x31_hold", rf_load[31], 32'hA5A5_001F);

        // 3: both requests, save wins; re-request during STORE ignored
        for (int i = 1; i < 32; i++) snap[i] = 32'h3000 + i;
        run_op(1'b1, 1'b1, 32'h0000_2000, 0, 33, 5, "dual");
        chk("dual_word_2004", mem[1], 32'h0000_3002);

        // 4: base wrap, slot 5 lands at address 0
        for (int i = 1; i < 32; i++) snap[i] = 32'h1000 + i;
        run_op(1'b1, 1'b0, 32'hFFFF_FFF0, 0, 33, 0, "wrap");
        chk("wrap_word_0000", mem[0],  32'h0000_1005);
        chk("wrap_word_fffc", mem[63], 32'h0000_1004);

        // 5: reset during LOAD at idx=10
        delay = 3;
        @(negedge clk);
        for (int k = 1; k <= 31; k++)
            sbq.push_back('{K_LD, 32'h0000_2000 + 32'((k - 1) * 4), 32'h0});
        restore_req = 1'b1;
        frame_base  = 32'h0000_2000;
        @(negedge clk);
        restore_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (mem_if.mem_addr_o == 32'h0000_2024) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_reached_idx10", found, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk_outputs_zero("midrst");
        sbq.delete();
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_still_idle", busy, 0);

        run_op(1'b1, 1'b0, 32'h0000_2000, 0, 33, 0, "postrst");

        // 6: save then restore through the same memory
        for (int i = 1; i < 32; i++) begin
            snap[i]     = 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
            exp_load[i] = snap[i];
        end
        run_op(1'b1, 1'b0, 32'h0000_2000, 0, 33, 0, "rt_save");
        for (int i = 1; i < 32; i++) snap[i] = 32'h0;
        run_op(1'b0, 1'b0, 32'h0000_2000, 1, 64, 0, "rt_restore");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mgt_01_ctx_save_restore.md
Name: mgt_01_ctx_save_restore

Overview:
Context save/restore engine that moves the integer register file to and from memory on interrupt entry and exit.
- Save: captures the register file's full-snapshot output in one cycle, then writes x1..x31 to a memory frame.
- Restore: reads x1..x31 back from the frame, then drives the register file's bulk-load port (sel_all + we + clk_en) for exactly one cycle.
- Sits between the interrupt controller, the integer register file and the data-memory port.

Parameters:
- XLEN, 32, data width and number of integer registers.
- WORD_BYTES, 4, byte stride between consecutive frame slots.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- save_req_i  in  1  start save; sampled only in IDLE.
- restore_req_i  in  1  start restore; sampled only in IDLE.
- frame_base_i  in  XLEN  frame base byte address; sampled at start.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when an operation completes.
- rf_snap_i  in  XLEN x XLEN  full register-file contents (entry 0 ignored).
- rf_load_o  out  XLEN x XLEN  bulk-load data to the register file (entry 0 driven 0).
- rf_sel_all_o  out  1  bulk-load select.
- rf_we_o  out  1  bulk-load write enable.
- rf_clk_en_o  out  1  bulk-load clock enable.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = store, 0 = load.
- mem_addr_o  out  XLEN  byte address.
- mem_wdata_o  out  XLEN  store data.
- mem_ack_i  in  1  transfer complete; for loads, mem_rdata_i is valid this cycle.
- mem_rdata_i  in  XLEN  load data.

Behaviour:
- Reset (synchronous, rst_i=1):
  - State to IDLE; index to 1.
  - All outputs 0: busy_o, done_o, rf_sel_all_o, rf_we_o, rf_clk_en_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rf_load_o.
  - Buffer cleared.
  - Reset mid-operation aborts the operation: no commit, no done pulse.
- Internal storage:
  - Buffer buf[1..31] of XLEN bits each.
  - 5-bit index idx, range 1..31.
  - Latched base address.
- States: IDLE, SNAP, STORE, LOAD, COMMIT, DONE.
- IDLE:
  - save_req_i -> SNAP; restore_req_i -> LOAD.
  - Both requests high: save wins; the restore request is dropped, not queued.
  - On either start: latch frame_base_i, set idx=1.
  - Requests arriving in any other state are ignored.
- SNAP (1 cycle): buf[i] <= rf_snap_i[i] for i=1..31, then -> STORE.
- STORE:
  - mem_req_o=1, mem_we_o=1.
  - mem_addr_o = base + (idx-1)*WORD_BYTES, mem_wdata_o = buf[idx].
  - Address arithmetic is modulo 2^XLEN; wrap-around is allowed and not flagged.
  - Outputs stay stable until mem_ack_i.
  - On ack: idx=31 -> DONE, else idx+1.
  - mem_req_o stays high across back-to-back slots: one transfer per ack, and an ack every cycle gives 31 consecutive cycles.
- LOAD:
  - Same address rule, mem_we_o=0, mem_wdata_o=0.
  - On ack: buf[idx] <= mem_rdata_i; idx=31 -> COMMIT, else idx+1.
- COMMIT (1 cycle):
  - rf_sel_all_o = rf_we_o = rf_clk_en_o = 1, rf_load_o[i] = buf[i].
  - Next state DONE.
- DONE (1 cycle): done_o=1, busy_o=1, next state IDLE.
- rf_load_o is driven from buf continuously; only the COMMIT strobe is significant.
- Latency with zero-wait memory (ack every cycle):
  - Save: start -> done_o = 1 (SNAP) + 31 + 1 = 33 cycles.
  - Restore: start -> done_o = 31 + 1 (COMMIT) + 1 = 33 cycles.
- x0 is never stored or loaded. The frame is 31 words (124 bytes).

Decomposition:
- Shared package (Modules_pkg):
  - ctx_state_e enum.
  - CTX_FRAME_WORDS = 31.
  - Reuse data_bus_t and XLEN.
- One sub-module, mgt_01_ctx_addr_gen: idx counter plus base + (idx-1)*WORD_BYTES adder, with load/increment/last outputs.

Test Plan:
- Save, zero-wait memory, rf_snap_i[i] = 0x1000+i, base 0x0000_2000 -> 31 stores at addresses 0x2000..0x2078; word at 0x2078 = 0x101F; done_o at cycle 33; rf_we_o never asserted.
- Restore, memory preloaded with word k = 0xA5A5_0000+k, ack delayed 3 cycles per transfer -> exactly one COMMIT cycle with rf_load_o[31] = 0xA5A5_001F and rf_load_o[0] = 0; mem_addr_o stable while waiting for ack.
- save_req_i and restore_req_i high together in IDLE -> save performed (mem_we_o=1), restore dropped; a new save_req_i pulse during STORE has no effect.
- Base 0xFFFF_FFF0 save -> the fifth slot (idx=5) address wraps to 0x0000_0000 without error.
- rst_i asserted during LOAD at idx=10 -> next cycle all outputs 0, no COMMIT, no done_o; a following save runs normally.
- Back-to-back save then restore through the same memory model -> restored rf_load_o equals the original snapshot for x1..x31.
